// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of one single-port synchronous RAM.
// Alternating priority on conflict; a valid/owner shift register routes each read response back.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int MEM_AW  = 10,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  output logic [31:0]       i_rsp_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [3:0]        d_req_we,
  input  logic [31:0]       d_req_wdata,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic               prio_d;
  logic               conflict, grant_i, grant_d;
  logic [LATENCY:1]   vld_pipe;
  logic [LATENCY:1]   own_pipe;   // 1 = access belongs to the D port

  // Grants come only from the valids and prio_d, never from the ready outputs.
  always_comb begin
    conflict = i_req_valid & d_req_valid;
    grant_d  = ~reset & d_req_valid & (~i_req_valid | prio_d);
    grant_i  = ~reset & i_req_valid & ~(d_req_valid & prio_d);
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  always_comb begin
    mem_en    = grant_i | grant_d;
    mem_we    = 4'b0000;
    mem_wdata = 32'h0;
    mem_addr  = '0;
    if (grant_d) begin
      mem_we    = d_req_we;
      mem_wdata = d_req_wdata;
      mem_addr  = d_req_addr[MEM_AW+1:2];
    end else if (grant_i) begin
      mem_addr  = i_req_addr[MEM_AW+1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_d   <= 1'b1;
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      if (conflict) prio_d <= ~prio_d;
      vld_pipe[1] <= grant_i | grant_d;
      own_pipe[1] <= grant_d;
      for (int k = 2; k <= LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        own_pipe[k] <= own_pipe[k-1];
      end
    end
  end

  // Tail of the tracker lines up with the RAM's read data.
  always_comb begin
    i_rsp_valid = ~reset & vld_pipe[LATENCY] & ~own_pipe[LATENCY];
    d_rsp_valid = ~reset & vld_pipe[LATENCY] &  own_pipe[LATENCY];
    i_rsp_rdata = i_rsp_valid ? mem_rdata : 32'h0;
    d_rsp_rdata = d_rsp_valid ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LATENCY 1 and 3) share stimulus; a reference
// model predicts grants and read data, and a negedge monitor scores every response.
module tb_mem_arbiter;

  logic        clk, reset;
  logic        iv, dv;
  logic [31:0] ia, da, dwd;
  logic [3:0]  dwe;

  logic        irdy[2], drdy[2], irv[2], drv[2], men[2];
  logic [31:0] ird[2], drd[2], mwd[2], mrd[2];
  logic [3:0]  mwe[2];
  logic [9:0]  madr[2];

  int lat[2] = '{1, 3};

  mem_arbiter #(.ADDR_W(32), .MEM_AW(10), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
    .i_req_valid(iv), .i_req_ready(irdy[0]), .i_req_addr(ia),
    .i_rsp_valid(irv[0]), .i_rsp_rdata(ird[0]),
    .d_req_valid(dv), .d_req_ready(drdy[0]), .d_req_addr(da),
    .d_req_we(dwe), .d_req_wdata(dwd),
    .d_rsp_valid(drv[0]), .d_rsp_rdata(drd[0]),
    .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(madr[0]),
    .mem_wdata(mwd[0]), .mem_rdata(mrd[0]));

  mem_arbiter #(.ADDR_W(32), .MEM_AW(10), .LATENCY(3)) u3 (
    .clk(clk), .reset(reset),
    .i_req_valid(iv), .i_req_ready(irdy[1]), .i_req_addr(ia),
    .i_rsp_valid(irv[1]), .i_rsp_rdata(ird[1]),
    .d_req_valid(dv), .d_req_ready(drdy[1]), .d_req_addr(da),
    .d_req_we(dwe), .d_req_wdata(dwd),
    .d_rsp_valid(drv[1]), .d_rsp_rdata(drd[1]),
    .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(madr[1]),
    .mem_wdata(mwd[1]), .mem_rdata(mrd[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAMs, read-first, one per instance with its own latency.
  logic [31:0] ram[2][1024];
  logic [31:0] rp[2][1:4];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (men[d]) begin
        rp[d][1] <= ram[d][madr[d]];
        for (int b = 0; b < 4; b++)
          if (mwe[d][b]) ram[d][madr[d]][8*b +: 8] <= mwd[d][8*b +: 8];
      end
      for (int k = 2; k <= 4; k++) rp[d][k] <= rp[d][k-1];
    end
  end
  assign mrd[0] = rp[0][1];
  assign mrd[1] = rp[1][3];

  typedef struct {
    int          dut;
    bit          is_d;
    logic [31:0] data;
    int          due;
    bit          chk;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem[1024];
  bit          prio_m;
  int          cyc;
  int          nvec, nerr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    bit   eg_i, eg_d;
    int   idx;
    exp_t e;
    logic [9:0] wa;
    eg_d = !reset && dv && (!iv || prio_m);
    eg_i = !reset && iv && !(dv && prio_m);
    wa   = eg_d ? da[11:2] : ia[11:2];
    for (int d = 0; d < 2; d++) begin
      idx = -1;
      foreach (q[j]) if (idx < 0 && q[j].dut == d) idx = j;
      if (reset) begin
        chk($sformatf("rsp_in_reset[%0d]", d), {30'd0, irv[d], drv[d]}, 0);
        for (int j = q.size() - 1; j >= 0; j--) if (q[j].dut == d) q.delete(j);
      end else if (irv[d] || drv[d]) begin
        if (idx < 0) chk($sformatf("spurious_rsp[%0d]", d), {30'd0, irv[d], drv[d]}, 0);
        else begin
          e = q[idx];
          q.delete(idx);
          chk($sformatf("rsp_port[%0d]", d), {30'd0, irv[d], drv[d]}, e.is_d ? 1 : 2);
          chk($sformatf("rsp_cycle[%0d]", d), cyc, e.due);
          if (e.chk) chk($sformatf("rsp_data[%0d]", d), e.is_d ? drd[d] : ird[d], e.data);
          chk($sformatf("rsp_other_rdata[%0d]", d), e.is_d ? ird[d] : drd[d], 0);
        end
      end else begin
        chk($sformatf("idle_rdata[%0d]", d), ird[d] | drd[d], 0);
        if (idx >= 0 && q[idx].due <= cyc) begin
          chk($sformatf("missing_rsp[%0d]", d), {30'd0, irv[d], drv[d]}, q[idx].is_d ? 1 : 2);
          q.delete(idx);
        end
      end
      chk($sformatf("i_ready[%0d]", d), irdy[d], eg_i);
      chk($sformatf("d_ready[%0d]", d), drdy[d], eg_d);
      chk($sformatf("mem_en[%0d]", d), men[d], eg_i | eg_d);
      if (eg_i || eg_d) begin
        chk($sformatf("mem_addr[%0d]", d), madr[d], wa);
        chk($sformatf("mem_we[%0d]", d), mwe[d], eg_d ? dwe : 4'b0000);
        chk($sformatf("mem_wdata[%0d]", d), mwd[d], eg_d ? dwd : 32'h0);
        e.dut  = d;
        e.is_d = eg_d;
        e.data = ref_mem[wa];
        e.due  = cyc + lat[d];
        e.chk  = !(eg_d && dwe != 4'b0000);
        q.push_back(e);
      end
    end
    if (eg_d)
      for (int b = 0; b < 4; b++) if (dwe[b]) ref_mem[wa][8*b +: 8] = dwd[8*b +: 8];
    if (reset) prio_m = 1'b1;
    else if (iv && dv) prio_m = ~prio_m;
  end

  task automatic drive(input bit r, input bit iv_, input logic [31:0] ia_,
                       input bit dv_, input logic [31:0] da_,
                       input logic [3:0] we_, input logic [31:0] wd_);
    reset = r; iv = iv_; ia = ia_; dv = dv_; da = da_; dwe = we_; dwd = wd_;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc = 0; nvec = 0; nerr = 0; prio_m = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      ref_mem[k] = 32'h1000_0000 + k;
      ram[0][k]  = 32'h1000_0000 + k;
      ram[1][k]  = 32'h1000_0000 + k;
    end
    // Reset with both valids high, then sustained contention from release.
    drive(1, 1, 32'h0, 1, 32'h40, 4'h0, 32'h0);
    drive(1, 1, 32'h0, 1, 32'h40, 4'h0, 32'h0);
    for (int k = 0; k < 6; k++) drive(0, 1, 32'h100 + 4*k, 1, 32'h200 + 4*k, 4'h0, 32'h0);
    // Fetch stream.
    drive(0, 1, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    drive(0, 1, 32'h4, 0, 32'h0, 4'h0, 32'h0);
    drive(0, 1, 32'h8, 0, 32'h0, 4'h0, 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    // Write, read, byte write, read.
    drive(0, 0, 32'h0, 1, 32'h10, 4'b1111, 32'hDEADBEEF);
    drive(0, 0, 32'h0, 1, 32'h10, 4'b0000, 32'h0);
    drive(0, 0, 32'h0, 1, 32'h10, 4'b0010, 32'h0000_5500);
    drive(0, 0, 32'h0, 1, 32'hFFFF_F013, 4'b0000, 32'h0);
    // Alternating I/D every cycle.
    for (int k = 0; k < 8; k++)
      drive(0, k % 2 == 0, 32'h300 + 4*k, k % 2 == 1, 32'h380 + 4*k, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) drive(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    // Reset mid-flight.
    drive(0, 1, 32'h20, 0, 32'h0, 4'h0, 32'h0);
    drive(0, 0, 32'h0, 1, 32'h24, 4'h0, 32'h0);
    drive(1, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    drive(0, 1, 32'h28, 0, 32'h0, 4'h0, 32'h0);
    for (int k = 0; k < 5; k++) drive(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    // Randomised traffic with occasional resets.
    for (int k = 0; k < 400; k++)
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 1) == 1, $urandom,
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, $urandom);
    for (int k = 0; k < 8; k++) drive(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    chk("pending_left", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
